queue_fetch: RTL and testbench
==============================

Name: queue_fetch

Overview:
- Read-side stage directly downstream of the queue controller.
- Issues pops into the controller's i_pop, tracks RAM reads in flight across a fixed RAM read latency, and captures returning read data into a small skid buffer.
- Presents that data on a valid/ready egress interface.
- Guarantees one word per cycle sustained throughput under continuous i_ready, and never overruns its buffer when i_ready stalls.

Parameters:
- W, 32, data word width.
- RAM_LAT, 1, cycles from pop (RAM read address/enable) to valid i_rdata; legal 1..3.
- SKID_N, RAM_LAT+2, skid buffer entries (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_empty  input  1  registered queue-empty status from controller; reflects all pops up to the previous cycle.
- o_pop  output  1  pop request; drives controller i_pop (RAM read enable).
- i_rdata  input  W  RAM read data; valid exactly RAM_LAT cycles after the corresponding o_pop.
- o_valid  output  1  egress data valid.
- o_data  output  W  egress data; head of skid buffer.
- i_ready  input  1  egress consumer ready.
- o_occ  output  $clog2(SKID_N+1)  skid entries currently held; debug/status only.

Behaviour:
- Reset (rst=1 at an edge):
  - credit counter = SKID_N; in-flight shift register cleared; skid rd/wr pointers = 0; occupancy = 0.
  - o_valid = 0 and o_occ = 0 from the following cycle.
  - o_pop is forced 0 combinationally while rst=1.
- Reset mid-operation:
  - In-flight reads and buffered words are discarded.
  - The controller is reset in the same cycle, so no credit is ever leaked.
- Pop issue: o_pop = ~rst & ~i_empty & (credit != 0). This is combinational. No other conditions apply, and o_pop does not depend on i_ready.
- Credit counter:
  - −1 on o_pop.
  - +1 on egress handshake (o_valid & i_ready).
  - Both in the same cycle: unchanged.
  - Range 0..SKID_N; an assertion fires on underflow or overflow.
- In-flight tracker:
  - Shift register of RAM_LAT bits.
  - Bit 0 is loaded with o_pop each cycle; it shifts every cycle with no stall.
  - The last bit marks cycles where i_rdata is valid.
- Capture: when the tracker's last bit is 1, i_rdata is written to skid[wr_ptr] at the clock edge, and wr_ptr increments modulo SKID_N.
- Egress:
  - o_valid = (occupancy != 0); o_data = skid[rd_ptr], driven from flops with no combinational path from i_rdata.
  - On o_valid & i_ready, rd_ptr increments modulo SKID_N.
  - Once asserted, o_valid and o_data remain stable until the handshake.
- Occupancy:
  - +1 on capture, −1 on handshake, unchanged when both occur.
  - Capture into a full buffer is impossible by the credit construction; an assertion fires if it happens.
- Latency: o_pop at cycle t, word present on o_data with o_valid=1 at cycle t+RAM_LAT+1.
- Throughput:
  - With i_empty=0 and i_ready=1 held, o_pop stays 1 every cycle and o_valid stays 1 after the initial fill.
  - A handshake at cycle t+RAM_LAT+1 returns its credit for a pop at t+RAM_LAT+2. SKID_N = RAM_LAT+2 therefore closes the loop with no bubble.
- Backpressure:
  - With i_ready=0, at most SKID_N pops are issued; then credit=0 and o_pop=0.
  - All issued reads land in the buffer.
- Pointer wrap: rd_ptr and wr_ptr wrap SKID_N−1 → 0. SKID_N need not be a power of two, so the wrap is by explicit compare.
- Ordering: words egress in strict pop order.

Test Plan:
1. RAM_LAT=1, rst held 3 cycles with i_empty=0 → o_pop=0 and o_valid=0 throughout; first cycle after rst drops → o_pop=1, credit 3→2.
2. RAM_LAT=1, queue preloaded 0xA0..0xA7, i_ready=1 constantly → o_pop 8 consecutive cycles; o_data 0xA0..0xA7 on 8 consecutive cycles starting 2 cycles after first pop; no o_valid gaps.
3. RAM_LAT=2, 10 words queued, i_ready=0 → exactly 4 pops then o_pop=0; o_occ settles at 4 holding words 0–3. Raise i_ready → words 0..9 in order, with o_pop resuming the cycle after the first handshake.
4. RAM_LAT=1, i_ready toggling 1/0 each cycle over 20 words → every word delivered once, in order; o_data stable across every valid-not-ready cycle; credit never exceeds 3 or goes below 0.
5. RAM_LAT=3, 6 words queued, i_empty rising the cycle after the 6th pop → exactly 6 pops, 6 egress words, then o_valid=0 and credit back at 5.
6. RAM_LAT=2, rst asserted with 2 reads in flight and 2 words buffered → next cycle o_valid=0 and o_occ=0; late i_rdata is ignored; a subsequent fresh sequence 0x11, 0x22 egresses exactly 0x11, 0x22.

Source files
------------

// File: rtl/queue_fetch.sv
// Read-side fetch stage: issues credit-limited pops into the queue controller, tracks RAM
// reads across a fixed latency, and lands the data in a skid buffer behind a valid/ready port.
module queue_fetch #(
  parameter int W       = 32,
  parameter int RAM_LAT = 1,
  parameter int SKID_N  = RAM_LAT + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_empty,
  output logic                        o_pop,
  input  logic [W-1:0]                i_rdata,
  output logic                        o_valid,
  output logic [W-1:0]                o_data,
  input  logic                        i_ready,
  output logic [$clog2(SKID_N+1)-1:0] o_occ
);

  localparam int CW = $clog2(SKID_N + 1);
  localparam int PW = $clog2(SKID_N);
  localparam logic [CW-1:0] FULL = CW'(SKID_N);
  localparam logic [PW-1:0] LAST = PW'(SKID_N - 1);

  logic [CW-1:0]      credit_q, credit_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic [RAM_LAT-1:0] infl_q, infl_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [W-1:0]       skid_q [SKID_N];
  logic               capture;
  logic               hs;

  // Egress: a word transfers on any cycle with o_valid & i_ready; once o_valid rises,
  // o_valid and o_data hold unchanged until that transfer happens.
  assign o_pop   = ~rst & ~i_empty & (credit_q != '0);
  assign o_valid = (occ_q != '0);
  assign o_data  = skid_q[rd_ptr_q];
  assign o_occ   = occ_q;
  assign hs      = o_valid & i_ready;
  assign capture = infl_q[RAM_LAT-1];

  always_comb begin
    credit_d = credit_q;
    if (o_pop && !hs)      credit_d = credit_q - CW'(1);
    else if (hs && !o_pop) credit_d = credit_q + CW'(1);

    occ_d = occ_q;
    if (capture && !hs)      occ_d = occ_q + CW'(1);
    else if (hs && !capture) occ_d = occ_q - CW'(1);

    infl_d    = '0;
    infl_d[0] = o_pop;
    for (int i = 1; i < RAM_LAT; i++) infl_d[i] = infl_q[i-1];

    // SKID_N is generally not a power of two, so pointers wrap by compare
    wr_ptr_d = wr_ptr_q;
    if (capture) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (hs) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= FULL;
      occ_q    <= '0;
      infl_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      credit_q <= credit_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) skid_q[wr_ptr_q] <= i_rdata;
  end

  // Credits bound pops to free skid slots, so none of these can trigger
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_credit_under : assert (!(o_pop && !hs && credit_q == '0));
      a_credit_over  : assert (!(hs && !o_pop && credit_q == FULL));
      a_skid_over    : assert (!(capture && !hs && occ_q == FULL));
    end
  end

endmodule

// File: tb/tb_queue_fetch.sv
// Bench for queue_fetch: three instances (RAM_LAT 1..3) share reset/ready and see the same
// word stream through per-instance queue-controller and RAM models; outputs checked each cycle.
module tb_queue_fetch;

  localparam int W  = 32;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic         empty [NI];
  logic [W-1:0] rdata [NI];
  logic         pop   [NI];
  logic         valid [NI];
  logic [W-1:0] data  [NI];
  logic [2:0]   occ   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L  = g + 1;
    localparam int OW = $clog2(L + 3);
    logic [OW-1:0] occ_w;
    queue_fetch #(.W(W), .RAM_LAT(L)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_empty (empty[g]),
      .o_pop   (pop[g]),
      .i_rdata (rdata[g]),
      .o_valid (valid[g]),
      .o_data  (data[g]),
      .i_ready (ready),
      .o_occ   (occ_w)
    );
    assign occ[g] = 3'(occ_w);
  end

  // Reference state: controller queue contents, popped-but-not-delivered words with pop cycle,
  // and a short history of what the RAM returns for each cycle
  logic [W-1:0] ctrl_q [NI][$];
  logic [W-1:0] exp_q  [NI][$];
  int           exp_t  [NI][$];
  logic [W-1:0] hist   [NI][8];
  int           cyc;
  int           n_total;
  int           n_bad;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic push_all(input logic [W-1:0] w);
    for (int k = 0; k < NI; k++) ctrl_q[k].push_back(w);
  endtask

  task automatic clear_ctrl();
    for (int k = 0; k < NI; k++) ctrl_q[k].delete();
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NI; k++) begin
      empty[k] = (ctrl_q[k].size() == 0);
      rdata[k] = hist[k][(cyc - (k + 1)) & 7];
    end
  endtask

  // One cycle: check outputs mid-cycle, advance the model across the edge, drive next inputs
  task automatic tick();
    int           lat;
    int           avail;
    logic         e_pop;
    logic         e_valid;
    logic         hs;
    logic [W-1:0] w;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      lat   = k + 1;
      avail = 0;
      for (int i = 0; i < exp_q[k].size(); i++)
        if (exp_t[k][i] + lat + 1 <= cyc) avail++;
      e_valid = (avail != 0);
      e_pop   = !rst && !empty[k] && (exp_q[k].size() < lat + 2);
      check($sformatf("L%0d_pop", lat), 32'(pop[k]), 32'(e_pop));
      check($sformatf("L%0d_valid", lat), 32'(valid[k]), 32'(e_valid));
      check($sformatf("L%0d_occ", lat), 32'(occ[k]), 32'(avail));
      if (e_valid) check($sformatf("L%0d_data", lat), data[k], exp_q[k][0]);
      hs = e_valid && ready;
      if (rst) begin
        exp_q[k].delete();
        exp_t[k].delete();
      end else if (hs) begin
        void'(exp_q[k].pop_front());
        void'(exp_t[k].pop_front());
      end
      w = $urandom();
      if (e_pop && ctrl_q[k].size() != 0) begin
        w = ctrl_q[k].pop_front();
        exp_q[k].push_back(w);
        exp_t[k].push_back(cyc);
      end
      hist[k][cyc & 7] = w;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 8;
    rst     = 1'b1;
    ready   = 1'b0;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 8; i++) hist[k][i] = $urandom();
    for (int i = 0; i < 4; i++) push_all(32'hB0 + i);
    drive_inputs();
    @(posedge clk);
    #1;

    // reset held with words waiting: no pops, no valid
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();

    // continuous streaming
    ready = 1'b1;
    for (int i = 0; i < 8; i++) push_all(32'hA0 + i);
    repeat (16) tick();

    // full backpressure, then release
    ready = 1'b0;
    for (int i = 0; i < 10; i++) push_all(32'h100 + i);
    repeat (12) tick();
    ready = 1'b1;
    repeat (20) tick();

    // ready toggling every cycle
    for (int i = 0; i < 20; i++) push_all(32'h200 + i);
    repeat (50) begin
      ready = ~ready;
      tick();
    end
    ready = 1'b1;
    repeat (10) tick();

    // short burst then queue runs empty
    for (int i = 0; i < 6; i++) push_all(32'h300 + i);
    repeat (15) tick();

    // reset with reads in flight and words buffered, then a fresh sequence
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push_all(32'h400 + i);
    repeat (4) tick();
    clear_ctrl();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_all(32'h11);
    push_all(32'h22);
    ready = 1'b1;
    repeat (10) tick();

    // randomized traffic with occasional resets
    repeat (400) begin
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 99) == 0);
      if (rst) clear_ctrl();
      if ($urandom_range(0, 2) == 0) push_all($urandom());
      tick();
    end
    rst   = 1'b0;
    ready = 1'b1;
    repeat (25) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
